dec_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 2:4 decoder. Drives its select a[1:0] and enable e.

---
 rtl/dec_scan_pkg.sv | 11 +
 rtl/dec_next_ch.sv | 33 +++
 rtl/dec_scan_ctrl.sv | 117 +++++++++++
 tb/tb_dec_scan_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dec_scan_pkg.sv
// Shared types and constants for the 2:4 decoder scan sequencer.
package dec_scan_pkg;
  localparam int NCH  = 4;
  localparam int CH_W = $clog2(NCH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BLANK
  } state_t;
endpackage

// File: rtl/dec_next_ch.sv
// Circular priority search: first set mask bit strictly after cur, wrapping 3->0.
module dec_next_ch
  import dec_scan_pkg::*;
(
  input  logic [CH_W-1:0] cur,
  input  logic [NCH-1:0]  mask,
  output logic [CH_W-1:0] nxt,
  output logic            wrap,
  output logic            none
);

  logic [CH_W-1:0] w_idx;
  logic            w_found;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    nxt     = cur;
    w_found = 1'b0;
    w_idx   = cur;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = cur + CH_W'(i);
      if (!w_found && mask[w_idx]) begin
        nxt     = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // A lone set bit finds itself after a full lap, which also counts as a wrap.
  assign wrap = (nxt <= cur);
  assign none = (mask == '0);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Round-robin scan sequencer driving a 2:4 decoder select/enable with dwell and blanking.
module dec_scan_ctrl
  import dec_scan_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [NCH-1:0]     mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CH_W-1:0]    a,
  output logic               e,
  output logic               busy,
  output logic               done,
  output logic               ch_tick
);

  localparam int BCNT_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [BCNT_W-1:0] BLANK_LOAD = (BLANK_CYC > 0) ? BCNT_W'(BLANK_CYC - 1) : '0;

  state_t              r_state;
  logic [CH_W-1:0]     r_cur;
  logic [DWELL_W-1:0]  r_cnt;
  logic [BCNT_W-1:0]   r_bcnt;
  logic                r_oneshot;
  logic                r_e;
  logic                r_busy;
  logic                r_done;
  logic                r_tick;

  logic [CH_W-1:0]     w_search_cur;
  logic [CH_W-1:0]     w_nxt;
  logic                w_wrap;
  logic                w_none;
  logic                w_advance;
  logic                w_adv_end;
  logic                w_enter;

  // From IDLE the search starts "after" the last channel, yielding the lowest set bit.
  assign w_search_cur = (r_state == S_IDLE) ? CH_W'(NCH - 1) : r_cur;

  dec_next_ch u_next_ch (
    .cur  (w_search_cur),
    .mask (mask),
    .nxt  (w_nxt),
    .wrap (w_wrap),
    .none (w_none)
  );

  assign w_advance = ((r_state == S_BLANK) && (r_bcnt == '0)) ||
                     ((r_state == S_ACTIVE) && (r_cnt == '0) && (BLANK_CYC == 0));
  assign w_adv_end = w_none || (w_wrap && r_oneshot);
  assign w_enter   = ((r_state == S_IDLE) && start && !w_none) ||
                     (w_advance && !w_adv_end);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_cnt     <= '0;
      r_bcnt    <= '0;
      r_oneshot <= 1'b0;
      r_e       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tick <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_e     <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_enter) begin
        if (r_state == S_IDLE) r_oneshot <= oneshot;
        r_state <= S_ACTIVE;
        r_cur   <= w_nxt;
        r_cnt   <= dwell;
        r_e     <= 1'b1;
        r_busy  <= 1'b1;
        r_tick  <= 1'b1;
      end else if (w_advance) begin
        r_state <= S_IDLE;
        r_e     <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          S_ACTIVE: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              r_state <= S_BLANK;
              r_bcnt  <= BLANK_LOAD;
              r_e     <= 1'b0;
            end
          end
          S_BLANK:  r_bcnt <= r_bcnt - 1'b1;
          S_IDLE:   r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign a       = r_cur;
  assign e       = r_e;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ch_tick = r_tick;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Self-checking bench for dec_scan_ctrl: directed vector table, corner sequences, random scans vs schedule model.
module tb_dec_scan_ctrl;

  localparam int DW    = 8;
  localparam int BLANK = 2;

  logic          clk = 1'b0;
  logic          rst, start, stop, oneshot;
  logic [3:0]    mask;
  logic [DW-1:0] dwell;
  logic [1:0]    a;
  logic          e, busy, done, ch_tick;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] prev_a;

  always #5 clk = ~clk;

  dec_scan_ctrl #(.DWELL_W(DW), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
    .mask(mask), .dwell(dwell), .a(a), .e(e), .busy(busy), .done(done), .ch_tick(ch_tick)
  );

  typedef struct {
    logic       rst, start, stop, oneshot;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [5:0] exp;   // {a, e, busy, done, ch_tick}
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic r, logic s, logic p, logic os, logic [3:0] m,
                              logic [7:0] dw, logic [1:0] xa, logic xe, logic xb, logic xd, logic xt);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.oneshot = os; v.mask = m; v.dwell = dw;
    v.exp = {xa, xe, xb, xd, xt};
    return v;
  endfunction

  function automatic logic [5:0] obs();
    return {a, e, busy, done, ch_tick};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Builds the expected output schedule from the channel list, dwell and blank lengths.
  task automatic run_segment(input logic [3:0] m, input logic [7:0] dw, input logic os,
                             input int ncyc, input string name);
    logic [5:0] q[$];
    int         chs[$];
    int         idx;
    logic [1:0] last;
    for (int i = 0; i < 4; i++) if (m[i]) chs.push_back(i);
    if (chs.size() == 0) begin
      while (q.size() < ncyc) q.push_back({prev_a, 4'b0000});
    end else begin
      idx = 0;
      while (q.size() < ncyc) begin
        for (int c = 0; c <= int'(dw); c++) q.push_back({2'(chs[idx]), 1'b1, 1'b1, 1'b0, (c == 0)});
        for (int c = 0; c < BLANK; c++) q.push_back({2'(chs[idx]), 4'b0100});
        idx++;
        if (idx == chs.size()) begin
          if (os) begin
            q.push_back({2'(chs[idx-1]), 4'b0010});
            while (q.size() < ncyc) q.push_back({2'(chs[idx-1]), 4'b0000});
          end
          idx = 0;
        end
      end
    end
    mask = m; dwell = dw; oneshot = os; start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      step();
      start = 1'b0;
      check($sformatf("%s cyc%0d", name, i), 32'(obs()), 32'(q[i]));
    end
    last = q[ncyc-1][5:4];
    stop = 1'b1;
    step();
    stop = 1'b0;
    check($sformatf("%s stop", name), 32'(obs()), 32'({last, 4'b0000}));
    prev_a = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] seq5 [7];
    int         cnt;

    rst = 1'b1; start = 1'b1; stop = 1'b0; oneshot = 1'b0; mask = 4'hF; dwell = '0;

    // Reset with start high; one-shot 1010 dwell 0; stop+start mid-ACTIVE; start with empty mask.
    tbl[0]  = mk(1, 1, 0, 0, 4'hF, 0, 2'd0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 4'hF, 0, 2'd0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 4'hF, 0, 2'd0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 1, 4'hA, 0, 2'd1, 1, 1, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 4'hA, 0, 2'd1, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 4'hA, 0, 2'd1, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 4'hA, 0, 2'd3, 1, 1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 4'hA, 0, 2'd3, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 4'hA, 0, 2'd3, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 4'hA, 0, 2'd3, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 4'hA, 0, 2'd3, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 4'h4, 3, 2'd2, 1, 1, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 4'h4, 3, 2'd2, 1, 1, 0, 0);
    tbl[13] = mk(0, 1, 1, 0, 4'h4, 3, 2'd2, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 4'h0, 3, 2'd2, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 4'h0, 3, 2'd2, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 4'h0, 3, 2'd2, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
      oneshot = tbl[i].oneshot; mask = tbl[i].mask; dwell = tbl[i].dwell;
      if (i == 0) #1; else step();
      if (i == 0) step();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end
    start = 1'b0;
    prev_a = 2'd2;

    run_segment(4'hF, 8'd2, 1'b0, 30, "cont1111");
    run_segment(4'h1, 8'd1, 1'b0, 20, "single0001");

    // Mask emptied during ACTIVE: channel completes, blanks, then done.
    seq5[0] = {2'd2, 4'b1101}; seq5[1] = {2'd2, 4'b1100}; seq5[2] = {2'd2, 4'b1100};
    seq5[3] = {2'd2, 4'b0100}; seq5[4] = {2'd2, 4'b0100}; seq5[5] = {2'd2, 4'b0010};
    seq5[6] = {2'd2, 4'b0000};
    mask = 4'h4; dwell = 8'd2; oneshot = 1'b0; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start = 1'b0;
      mask  = 4'h0;
      check($sformatf("maskdrop cyc%0d", i), 32'(obs()), 32'(seq5[i]));
    end

    // Reset in the middle of BLANK.
    mask = 4'h6; dwell = 8'd0; oneshot = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    check("rstblank active", 32'(obs()), 32'({2'd1, 4'b1101}));
    step();
    check("rstblank blank", 32'(obs()), 32'({2'd1, 4'b0100}));
    rst = 1'b1;
    step();
    check("rstblank reset", 32'(obs()), 32'(6'b0));
    rst = 1'b0;
    step();
    check("rstblank idle", 32'(obs()), 32'(6'b0));

    // Maximum dwell: e must stay high for exactly 256 cycles.
    mask = 4'h1; dwell = 8'd255; oneshot = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300 && e; i++) begin
      cnt++;
      step();
    end
    check("dwell255 e cycles", 32'(cnt), 32'd256);
    check("dwell255 blank1", 32'(obs()), 32'({2'd0, 4'b0100}));
    step();
    check("dwell255 blank2", 32'(obs()), 32'({2'd0, 4'b0100}));
    step();
    check("dwell255 done", 32'(obs()), 32'({2'd0, 4'b0010}));
    step();
    check("dwell255 idle", 32'(obs()), 32'({2'd0, 4'b0000}));
    prev_a = 2'd0;

    for (int r = 0; r < 25; r++) begin
      run_segment(4'($urandom_range(0, 15)), 8'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), int'($urandom_range(1, 40)),
                  $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
